// File: rtl/outputc_if.sv
// Flit link bundle between crossbar, output channel and downstream input.
// Field widths come from the flit-format macros below.
`ifndef DATAW
`define DATAW 35
`endif
`ifndef VCHW
`define VCHW 0
`endif
`ifndef VCH
`define VCH 0
`endif
`ifndef TYPE_MSB
`define TYPE_MSB 35
`endif
`ifndef TYPE_LSB
`define TYPE_LSB 34
`endif
`ifndef TYPE_BODY
`define TYPE_BODY 2'b00
`endif
`ifndef TYPE_HEAD
`define TYPE_HEAD 2'b01
`endif
`ifndef TYPE_TAIL
`define TYPE_TAIL 2'b10
`endif
`ifndef TYPE_HEADTAIL
`define TYPE_HEADTAIL 2'b11
`endif

interface outputc_if;
  logic [`DATAW:0] idata;
  logic            ivalid;
  logic [`VCHW:0]  ivch;
  logic [`VCH:0]   iack;
  logic [`DATAW:0] odata;
  logic            ovalid;
  logic [`VCHW:0]  ovch;
  logic [`VCH:0]   ordy;
  logic [`VCH:0]   olck;

  modport master (
    output idata, ivalid, ivch, iack,
    input  odata, ovalid, ovch, ordy, olck
  );

  modport slave (
    input  idata, ivalid, ivch, iack,
    output odata, ovalid, ovch, ordy, olck
  );
endinterface

// File: rtl/outputc.sv
// Output channel: registers flits onto the link, credit flow control.
// OUTPUTC_PKTCNT_EN adds a 16-bit sent-packet counter on pktcnt.
`ifndef DATAW
`define DATAW 35
`endif
`ifndef VCHW
`define VCHW 0
`endif
`ifndef VCH
`define VCH 0
`endif
`ifndef TYPE_MSB
`define TYPE_MSB 35
`endif
`ifndef TYPE_LSB
`define TYPE_LSB 34
`endif
`ifndef TYPE_BODY
`define TYPE_BODY 2'b00
`endif
`ifndef TYPE_HEAD
`define TYPE_HEAD 2'b01
`endif
`ifndef TYPE_TAIL
`define TYPE_TAIL 2'b10
`endif
`ifndef TYPE_HEADTAIL
`define TYPE_HEADTAIL 2'b11
`endif

module outputc #(
  parameter int ROUTERID  = 0,
  parameter int PCHID     = 0,
  parameter int BUF_DEPTH = 4,
  parameter int CRDW      = 2
) (
  input  logic        clk,
  input  logic        rst_,
  outputc_if.slave    lnk,
  output logic        err,
  output logic [15:0] pktcnt
);

  typedef enum logic {IDLE, ACTIVE} state_e;

  localparam logic [CRDW:0] CRD_MAX = (CRDW+1)'(BUF_DEPTH);

  if (ROUTERID < 0 || PCHID < 0) begin : g_bad_id
  end

  state_e          state_q, state_d;
  logic [CRDW:0]   credit_q, credit_d;
  logic [`DATAW:0] odata_q, odata_d;
  logic [`VCHW:0]  ovch_q, ovch_d;
  logic            ovalid_q, ovalid_d;
  logic            err_q, err_d;

  logic [1:0] ftype;
  logic       is_head, is_tail, is_body, is_ht;
  logic       vc_ok, has_crd, full, ack, accept;
  logic       proto_err, ovf;

  always_comb begin
    ftype   = lnk.idata[`TYPE_MSB:`TYPE_LSB];
    is_head = ftype == `TYPE_HEAD;
    is_tail = ftype == `TYPE_TAIL;
    is_body = ftype == `TYPE_BODY;
    is_ht   = ftype == `TYPE_HEADTAIL;
    vc_ok   = lnk.ivch == '0;
    has_crd = credit_q != '0;
    full    = credit_q == CRD_MAX;
    ack     = lnk.iack[0];
    accept  = lnk.ivalid & vc_ok & has_crd;
    ovf     = ack & ~accept & full;
  end

  // Simultaneous accept and return cancel out.
  always_comb begin
    credit_d = credit_q;
    unique case (1'b1)
      accept & ~ack:         credit_d = credit_q - 1'b1;
      ~accept & ack & ~full: credit_d = credit_q + 1'b1;
      default: ;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    proto_err = 1'b0;
    if (accept) begin
      unique case (state_q)
        IDLE: begin
          if (is_head) state_d = ACTIVE;
          else if (!is_ht) proto_err = 1'b1;
        end
        ACTIVE: begin
          if (is_tail) state_d = IDLE;
          else if (!is_body) proto_err = 1'b1;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_comb begin
    odata_d  = accept ? lnk.idata : '0;
    ovch_d   = accept ? lnk.ivch : '0;
    ovalid_d = accept;
    err_d    = err_q | proto_err | ovf
             | (lnk.ivalid & ~vc_ok)
             | (lnk.ivalid & vc_ok & ~has_crd);
  end

  always_ff @(posedge clk) begin
    if (rst_) begin
      state_q  <= IDLE;
      credit_q <= CRD_MAX;
      odata_q  <= '0;
      ovch_q   <= '0;
      ovalid_q <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      credit_q <= credit_d;
      odata_q  <= odata_d;
      ovch_q   <= ovch_d;
      ovalid_q <= ovalid_d;
      err_q    <= err_d;
    end
  end

  assign lnk.odata  = odata_q;
  assign lnk.ovch   = ovch_q;
  assign lnk.ovalid = ovalid_q;
  assign lnk.ordy   = (`VCH+1)'(has_crd & ~rst_);
  assign lnk.olck   = (`VCH+1)'(state_q == ACTIVE);
  assign err        = err_q;

`ifdef OUTPUTC_PKTCNT_EN
  logic [15:0] pktcnt_q, pktcnt_d;
  logic        pkt_end;

  always_comb begin
    pkt_end  = accept & ((state_q == IDLE) ? is_ht : is_tail);
    pktcnt_d = pktcnt_q + 16'(pkt_end);
  end

  always_ff @(posedge clk) begin
    if (rst_) pktcnt_q <= '0;
    else      pktcnt_q <= pktcnt_d;
  end

  assign pktcnt = pktcnt_q;
`else
  assign pktcnt = 16'h0;
`endif

endmodule

// File: tb/tb_outputc.sv
// Randomized scoreboard bench for outputc.
// Link flits are checked by a monitor against a queue filled by the driver.
module tb_outputc;

  localparam logic [1:0] T_BODY = `TYPE_BODY;
  localparam logic [1:0] T_HEAD = `TYPE_HEAD;
  localparam logic [1:0] T_TAIL = `TYPE_TAIL;
  localparam logic [1:0] T_HT   = `TYPE_HEADTAIL;

  logic        clk = 1'b0;
  logic        rst_;
  logic        err;
  logic [15:0] pktcnt;

  outputc_if lnk();

  outputc #(.ROUTERID(0), .PCHID(0), .BUF_DEPTH(4), .CRDW(2)) dut (
    .clk(clk), .rst_(rst_), .lnk(lnk), .err(err), .pktcnt(pktcnt)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [`DATAW:0] exp_d[$];
  logic [`VCHW:0]  exp_v[$];

  // Reference model state: packet-level view of the link.
  int   m_credit = 4;
  bit   m_in_pkt = 0;
  bit   m_err = 0;
  int   m_pkt = 0;
  bit   m_rst = 1;

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(posedge clk) begin
    #1;
    if (lnk.ovalid === 1'b1) begin
      if (exp_d.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_flit: got %0h want none", lnk.odata);
      end else begin
        chk("odata", 64'(lnk.odata), 64'(exp_d.pop_front()));
        chk("ovch", 64'(lnk.ovch), 64'(exp_v.pop_front()));
      end
    end else begin
      chk("idle_odata", 64'(lnk.odata), 64'h0);
    end
  end

  task automatic step(input bit r, input bit v, input logic [`VCHW:0] ch,
                      input logic [1:0] ty, input logic [`DATAW:0] pay,
                      input bit ack);
    logic [`DATAW:0] f;
    bit acc;
    int exp_pc;
    f = pay;
    f[`TYPE_MSB:`TYPE_LSB] = ty;
    rst_ = r;
    lnk.ivalid = v;
    lnk.ivch = ch;
    lnk.idata = f;
    lnk.iack = (`VCH+1)'(ack);
    m_rst = r;
    if (r) begin
      m_credit = 4;
      m_in_pkt = 0;
      m_err = 0;
      m_pkt = 0;
    end else begin
      acc = v && ch == 0 && m_credit > 0;
      if (v && !acc) m_err = 1;
      if (acc) begin
        exp_d.push_back(f);
        exp_v.push_back(ch);
        if (!m_in_pkt) begin
          if (ty == T_HEAD) m_in_pkt = 1;
          else if (ty == T_HT) m_pkt = (m_pkt + 1) & 16'hFFFF;
          else m_err = 1;
        end else begin
          if (ty == T_TAIL) begin
            m_in_pkt = 0;
            m_pkt = (m_pkt + 1) & 16'hFFFF;
          end else if (ty != T_BODY) m_err = 1;
        end
      end
      m_credit = m_credit - int'(acc) + int'(ack);
      if (m_credit > 4) begin
        m_credit = 4;
        m_err = 1;
      end
    end
    @(posedge clk);
    @(negedge clk);
`ifdef OUTPUTC_PKTCNT_EN
    exp_pc = m_pkt;
`else
    exp_pc = 0;
`endif
    chk("ordy", 64'(lnk.ordy[0]), 64'(!m_rst && m_credit != 0));
    chk("olck", 64'(lnk.olck[0]), 64'(m_in_pkt));
    chk("err", 64'(err), 64'(m_err));
    chk("pktcnt", 64'(pktcnt), 64'(exp_pc));
  endtask

  task automatic idle(input bit ack);
    step(0, 0, '0, T_BODY, '0, ack);
  endtask

  task automatic send(input logic [1:0] ty, input logic [`DATAW:0] pay,
                      input bit ack);
    step(0, 1, '0, ty, pay, ack);
  endtask

  function automatic logic [`DATAW:0] rnd_pay();
    return (`DATAW+1)'({$urandom, $urandom});
  endfunction

  initial begin
    rst_ = 1'b1;
    lnk.ivalid = 1'b0;
    lnk.ivch = '0;
    lnk.idata = '0;
    lnk.iack = '0;

    step(1, 0, '0, T_BODY, '0, 0);
    step(1, 0, '0, T_BODY, '0, 0);
    idle(0);

    send(T_HT, (`DATAW+1)'(36'h0_1234_56A5), 0);
    idle(0);
    idle(1);

    send(T_HEAD, rnd_pay(), 0);
    for (int i = 0; i < 4; i++) send(T_BODY, rnd_pay(), 0);
    idle(0);

    idle(1);
    send(T_BODY, rnd_pay(), 1);
    send(T_TAIL, rnd_pay(), 1);
    idle(1);
    idle(1);

    step(1, 0, '0, T_BODY, '0, 0);
    send(T_HEAD, rnd_pay(), 1);
    send(T_BODY, rnd_pay(), 1);
    send(T_TAIL, rnd_pay(), 1);
    idle(0);

    send(T_BODY, rnd_pay(), 0);
    send(T_HEAD, rnd_pay(), 0);
    step(1, 0, '0, T_BODY, '0, 0);
    idle(0);

    step(0, 1, 1'b1, T_HT, rnd_pay(), 0);
    step(1, 0, '0, T_BODY, '0, 0);

    for (int i = 0; i < 600; i++) begin
      bit r, v, a;
      logic [`VCHW:0] ch;
      r  = ($urandom_range(0, 99) == 0);
      v  = ($urandom_range(0, 9) < 7);
      a  = ($urandom_range(0, 9) < 4);
      ch = ($urandom_range(0, 19) == 0) ? 1'b1 : 1'b0;
      step(r, v, ch, 2'($urandom_range(0, 3)), rnd_pay(), a);
    end

    idle(0);
    idle(0);
    chk("sb_empty", 64'(exp_d.size()), 64'h0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
